// File: rtl/pwm_puente_h.sv
// rtl/pwm_puente_h.sv - signed control word to PWM magnitude + direction for an H-bridge
//
// Purpose: turns the signed I-PD control effort into a fixed-frequency PWM
// (period 2^W clocks) plus a direction bit. A new command is captured on each
// enable strobe and only takes effect at a period boundary. Reversing the
// direction inserts two dead-time halves of DEADTIME clocks each, with PWM off,
// before the first period in the new direction.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   enable       control-sample strobe; IPD is valid while high
//   IPD          signed control effort, Decimal fractional bits
//   pwm          registered H-bridge enable / PWM
//   dir          registered direction, 0 = forward, 1 = reverse
//   sat          registered, high while the active duty was clipped
//   period_start registered one-cycle pulse at the start of each RUN period
//
// All four outputs are the registered image of the internal state of the
// previous clock, so they move together with a uniform one-clock latency and
// no combinational path from IPD or enable reaches them.

module pwm_puente_h #(
  parameter int Magnitud = 17,
  parameter int Decimal  = 0,
  parameter int N        = Magnitud + Decimal + 1,
  parameter int W        = 10,
  parameter int DEADTIME = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic signed [N-1:0] IPD,
  output logic                pwm,
  output logic                dir,
  output logic                sat,
  output logic                period_start
);

  localparam int             DTW      = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [N:0]     max_wide = (N+1)'((1 << W) - 1);
  localparam logic [DTW-1:0] dt_last  = DTW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    st_run   = 2'd0,
    st_dead1 = 2'd1,
    st_dead2 = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   cnt, cnt_n;
  logic [DTW-1:0] dt_cnt, dt_cnt_n;
  logic [W-1:0]   duty_act, duty_act_n;
  logic           sat_cur, sat_cur_n;
  logic           dir_cur, dir_cur_n;

  logic [W-1:0]   duty_pend;
  logic           sat_pend;
  logic           dir_pend;

  // Sample path: integer part, magnitude and clipping of the control word.
  logic signed [N-1:0] v;
  logic signed [N:0]   v_ext;
  logic [N:0]          mag;
  logic                sat_in;
  logic [W-1:0]        duty_in;

  always_comb begin
    v       = IPD >>> Decimal;
    // One extra bit so that |-2^(N-1)| does not wrap back to a negative value.
    v_ext   = {v[N-1], v};
    mag     = v[N-1] ? $unsigned(-v_ext) : $unsigned(v_ext);
    sat_in  = (mag > max_wide);
    duty_in = sat_in ? '1 : mag[W-1:0];
  end

  // Pending command: last strobe before the boundary wins. A zero magnitude
  // carries no sign information, so the previous direction is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_pend <= '0;
      sat_pend  <= 1'b0;
      dir_pend  <= 1'b0;
    end else if (enable) begin
      duty_pend <= duty_in;
      sat_pend  <= sat_in;
      if (mag != '0) begin
        dir_pend <= v[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= st_run;
      cnt      <= '0;
      dt_cnt   <= '0;
      duty_act <= '0;
      sat_cur  <= 1'b0;
      dir_cur  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dt_cnt   <= dt_cnt_n;
      duty_act <= duty_act_n;
      sat_cur  <= sat_cur_n;
      dir_cur  <= dir_cur_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dt_cnt_n   = dt_cnt;
    duty_act_n = duty_act;
    sat_cur_n  = sat_cur;
    dir_cur_n  = dir_cur;

    case (state)
      st_run: begin
        if (&cnt) begin
          cnt_n = '0;
          // A zero duty drives nothing, so no dead time is needed even if
          // the pending sign differs; the direction is simply left alone.
          if ((dir_pend == dir_cur) || (duty_pend == '0)) begin
            duty_act_n = duty_pend;
            sat_cur_n  = sat_pend;
          end else begin
            state_n  = st_dead1;
            dt_cnt_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      st_dead1: begin
        cnt_n = '0;
        if (dt_cnt == dt_last) begin
          // Re-read dir_pend here: a command that flipped back during DEAD1
          // leaves dir unchanged, but DEAD2 still runs.
          dir_cur_n = dir_pend;
          state_n   = st_dead2;
          dt_cnt_n  = '0;
        end else begin
          dt_cnt_n = dt_cnt + 1'b1;
        end
      end

      st_dead2: begin
        cnt_n = '0;
        if (dt_cnt == dt_last) begin
          duty_act_n = duty_pend;
          sat_cur_n  = sat_pend;
          state_n    = st_run;
          dt_cnt_n   = '0;
        end else begin
          dt_cnt_n = dt_cnt + 1'b1;
        end
      end

      default: begin
        state_n  = st_run;
        cnt_n    = '0;
        dt_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm          <= 1'b0;
      dir          <= 1'b0;
      sat          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm          <= (state == st_run) && (cnt < duty_act);
      period_start <= (state == st_run) && (cnt == '0);
      dir          <= dir_cur;
      sat          <= sat_cur;
    end
  end

endmodule

// File: tb/tb_pwm_puente_h.sv
// tb/tb_pwm_puente_h.sv - self-checking bench for pwm_puente_h

module tb_pwm_puente_h;

  localparam int W      = 4;
  localparam int DT     = 2;
  localparam int MAG    = 17;
  localparam int DEC    = 0;
  localparam int N      = 18;
  localparam int PERIOD = 1 << W;
  localparam int MAXD   = PERIOD - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                enable = 1'b0;
  logic signed [N-1:0] ipd = '0;
  logic                pwm, dir, sat, period_start;

  always #5 clk = ~clk;

  pwm_puente_h #(
    .Magnitud(MAG),
    .Decimal (DEC),
    .N       (N),
    .W       (W),
    .DEADTIME(DT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .IPD         (ipd),
    .pwm         (pwm),
    .dir         (dir),
    .sat         (sat),
    .period_start(period_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the period, remaining dead clocks
  // (counting down over both halves), active and pending command.
  int m_pos, m_dead, m_duty, m_sat, m_dir;
  int p_duty, p_sat, p_dir;
  int e_pwm, e_dir, e_sat, e_ps;

  typedef struct {
    int ipd;
    int duty;
    int sat;
    int dir;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dead = 0; m_duty = 0; m_sat = 0; m_dir = 0;
    p_duty = 0; p_sat = 0; p_dir = 0;
  endtask

  task automatic model_step(input bit en, input int v);
    int mag;
    e_pwm = (m_dead == 0 && m_pos < m_duty) ? 1 : 0;
    e_ps  = (m_dead == 0 && m_pos == 0) ? 1 : 0;
    e_dir = m_dir;
    e_sat = m_sat;
    if (m_dead == 0) begin
      if (m_pos == PERIOD - 1) begin
        if (p_dir == m_dir || p_duty == 0) begin
          m_duty = p_duty; m_sat = p_sat; m_pos = 0;
        end else begin
          m_dead = 2 * DT;
        end
      end else begin
        m_pos++;
      end
    end else begin
      m_dead--;
      if (m_dead == DT) m_dir = p_dir;
      if (m_dead == 0) begin
        m_duty = p_duty; m_sat = p_sat; m_pos = 0;
      end
    end
    if (en) begin
      mag = (v < 0) ? -v : v;
      if (mag > MAXD) begin
        p_duty = MAXD; p_sat = 1;
      end else begin
        p_duty = mag; p_sat = 0;
      end
      if (mag != 0) p_dir = (v < 0) ? 1 : 0;
    end
  endtask

  task automatic tick(input bit en, input int v);
    enable = en;
    ipd    = N'(v);
    @(posedge clk);
    if (reset) begin
      model_step(en, v);
    end else begin
      e_pwm = 0; e_dir = 0; e_sat = 0; e_ps = 0;
    end
    #1;
    chk("pwm", pwm, e_pwm);
    chk("dir", dir, e_dir);
    chk("sat", sat, e_sat);
    chk("period_start", period_start, e_ps);
  endtask

  task automatic wait_ps(output int cyc);
    cyc = 0;
    do begin
      tick(1'b0, 0);
      cyc++;
    end while (!period_start && cyc < 100);
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL wait_ps: got no period_start within %0d clocks expected a pulse", cyc);
    end
  endtask

  task automatic count_period(output int hi);
    hi = int'(pwm);
    for (int i = 1; i < PERIOD; i++) begin
      tick(1'b0, 0);
      hi += int'(pwm);
    end
  endtask

  initial begin
    int c, hi, n;
    vecs[0] = '{ipd:      5, duty:  5, sat: 0, dir: 0};
    vecs[1] = '{ipd:    200, duty: 15, sat: 1, dir: 0};
    vecs[2] = '{ipd: -131072, duty: 15, sat: 1, dir: 1};
    vecs[3] = '{ipd:     -3, duty:  3, sat: 0, dir: 1};
    vecs[4] = '{ipd:      0, duty:  0, sat: 0, dir: 1};
    vecs[5] = '{ipd:     15, duty: 15, sat: 0, dir: 0};
    vecs[6] = '{ipd:     16, duty: 15, sat: 1, dir: 0};
    vecs[7] = '{ipd:     -1, duty:  1, sat: 0, dir: 1};
    vecs[8] = '{ipd:      0, duty:  0, sat: 0, dir: 1};
    vecs[9] = '{ipd:      7, duty:  7, sat: 0, dir: 0};

    model_reset();
    #2;
    tick(1'b0, 0);
    tick(1'b1, 9);
    reset = 1'b1;

    tick(1'b0, 0);
    chk("ps after release", period_start, 1);
    wait_ps(c);
    chk("idle period length", c, PERIOD);
    chk("idle pwm", pwm, 0);

    foreach (vecs[k]) begin
      n = $urandom_range(0, PERIOD - 1);
      for (int i = 0; i < n; i++) tick(1'b0, 0);
      tick(1'b1, vecs[k].ipd);
      wait_ps(c);
      wait_ps(c);
      count_period(hi);
      chk("vec duty", hi, vecs[k].duty);
      chk("vec sat", sat, vecs[k].sat);
      chk("vec dir", dir, vecs[k].dir);
    end

    // Forward +5, then reverse to -3: the period is stretched by 2*DT.
    tick(1'b1, 5);
    wait_ps(c);
    wait_ps(c);
    tick(1'b1, -3);
    wait_ps(c);
    chk("reversal gap", c + 1, PERIOD + 2 * DT);
    chk("reversal dir", dir, 1);
    count_period(hi);
    chk("reversal duty", hi, 3);

    // Two strobes in one period: the second one wins.
    tick(1'b0, 0);
    tick(1'b1, 7);
    tick(1'b0, 0);
    tick(1'b1, 2);
    wait_ps(c);
    count_period(hi);
    chk("last strobe wins", hi, 2);

    // Zero command after a negative run: no dead time, direction kept.
    tick(1'b1, -4);
    wait_ps(c);
    wait_ps(c);
    tick(1'b1, 0);
    wait_ps(c);
    chk("zero no dead gap", c + 1, PERIOD);
    count_period(hi);
    chk("zero duty", hi, 0);
    chk("zero keeps dir", dir, 1);

    // Reset in the middle of DEAD1 while dir is still 1.
    tick(1'b1, 6);
    n = 0;
    do begin
      tick(1'b0, 0);
      n++;
    end while (m_dead != 2 * DT && n < 40);
    chk("reached dead1", m_dead, 2 * DT);
    tick(1'b0, 0);
    chk("dir before reset", dir, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async pwm", pwm, 0);
    chk("async dir", dir, 0);
    chk("async sat", sat, 0);
    chk("async ps", period_start, 0);
    model_reset();
    tick(1'b0, 0);
    tick(1'b0, 0);
    reset = 1'b1;
    tick(1'b0, 0);
    chk("ps after dead reset", period_start, 1);
    count_period(hi);
    chk("duty after reset", hi, 0);

    // Randomized strobes and values against the model.
    for (int i = 0; i < 600; i++) begin
      int r, v;
      r = $urandom_range(0, 9);
      if (r < 7)       v = $urandom_range(0, 40) - 20;
      else if (r == 7) v = 131071;
      else if (r == 8) v = -131072;
      else             v = $urandom_range(0, 400) - 200;
      tick(($urandom_range(0, 7) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
